// File: rtl/mont_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-K mod M.
// One operand bit per cycle (K cycles), then one final conditional subtract.
`timescale 1ns/1ps
module mont_mul_serial #(
  parameter int          K    = 192,
  parameter int          LOGK = 8,
  parameter logic [K-1:0] M   = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K-1:0] result,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_e;

  localparam logic [LOGK-1:0] LAST  = LOGK'(K - 1);
  // (t + M) / 2 for odd t equals floor(t / 2) + (M + 1) / 2, since M is odd
  localparam logic [K:0]      MHALF = {2'b00, M[K-1:1]} + (K+1)'(1);

  state_e          state_q, state_d;
  logic [K-1:0]    ra_q, ra_d;
  logic [K-1:0]    rb_q, rb_d;
  logic [K:0]      acc_q, acc_d;
  logic [LOGK-1:0] cnt_q, cnt_d;
  logic [K-1:0]    result_q, result_d;
  logic            done_q, done_d;

  logic [K+1:0]    tSum;
  logic [K:0]      accNext;
  logic [K:0]      accMinusM;
  logic            accGeM;

  always_comb begin
    tSum      = {1'b0, acc_q} + (ra_q[cnt_q] ? {2'b00, rb_q} : '0);
    accNext   = tSum[K+1:1] + (tSum[0] ? MHALF : '0);
    accMinusM = acc_q - {1'b0, M};
    accGeM    = (acc_q >= {1'b0, M});
  end

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = accNext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FINAL;
      end
      FINAL: begin
        result_d = accGeM ? accMinusM[K-1:0] : acc_q[K-1:0];
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        // a held start keeps us here; a low start releases after one cycle
        done_d = 1'b1;
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mont_mul_serial.sv
// Scoreboard bench for mont_mul_serial: a 192-bit default instance and a K=8, M=239 instance.
// Stimulus pushes expected results; per-instance monitors pop on each rising done.
`timescale 1ns/1ps
module tb_mont_mul_serial;

  localparam int KB = 192;
  localparam int KS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          startBig, startSmall;
  logic [KB-1:0] aBig, bBig, resultBig;
  logic [KS-1:0] aSmall, bSmall, resultSmall;
  logic          doneBig, doneSmall;
  logic          doneBigPrev = 1'b0, doneSmallPrev = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [191:0] expBig[$];
  logic [191:0] expSmall[$];

  always #5 clk = ~clk;

  mont_mul_serial dutBig (
    .clk(clk), .rst_n(rst_n), .start(startBig), .a(aBig), .b(bBig),
    .result(resultBig), .done(doneBig)
  );

  mont_mul_serial #(.K(KS), .LOGK(4), .M(8'hEF)) dutSmall (
    .clk(clk), .rst_n(rst_n), .start(startSmall), .a(aSmall), .b(bSmall),
    .result(resultSmall), .done(doneSmall)
  );

  task automatic checkOutput(input string name, input logic [191:0] actual,
                             input logic [191:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // monitors: compare against the scoreboard whenever done rises
  always @(negedge clk) begin
    if (doneBig && !doneBigPrev) begin
      if (expBig.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL big_unexpected_done: got result %h, expected no completion", resultBig);
      end else checkOutput("big_result", resultBig, expBig.pop_front());
    end
    doneBigPrev = doneBig;
  end

  always @(negedge clk) begin
    if (doneSmall && !doneSmallPrev) begin
      if (expSmall.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL small_unexpected_done: got result %h, expected no completion", resultSmall);
      end else checkOutput("small_result", {184'b0, resultSmall}, expSmall.pop_front());
    end
    doneSmallPrev = doneSmall;
  end

  // mode 0: pulse start; mode 1: hold start; mode 2: pulse, then disturb start/a/b during CALC
  task automatic applyStimulus(input bit isSmall, input logic [191:0] aVal, input logic [191:0] bVal,
                               input logic [191:0] expVal, input int mode, input string tag);
    int  lat;
    bit  seen;
    int  kk;
    kk = isSmall ? KS : KB;
    @(negedge clk);
    if (isSmall) begin
      aSmall = aVal[7:0]; bSmall = bVal[7:0]; startSmall = 1'b1;
      expSmall.push_back(expVal);
    end else begin
      aBig = aVal; bBig = bVal; startBig = 1'b1;
      expBig.push_back(expVal);
    end
    @(posedge clk);
    @(negedge clk);
    if (mode != 1) begin
      if (isSmall) startSmall = 1'b0; else startBig = 1'b0;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < kk + 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if ((isSmall ? doneSmall : doneBig) === 1'b1) seen = 1'b1;
      else if (mode == 2) begin
        if (isSmall) begin
          startSmall = (lat < kk - 2) ? lat[0] : 1'b0;
          aSmall = 8'($urandom);
          bSmall = 8'($urandom);
        end else begin
          startBig = (lat < kk - 2) ? lat[0] : 1'b0;
          aBig = KB'($urandom);
          bBig = KB'($urandom);
        end
      end
    end
    checkOutput({tag, "_latency"}, 192'(lat), 192'(kk + 1));
    if (mode == 1) begin
      repeat (3) begin
        @(negedge clk);
        checkOutput({tag, "_held_done"}, {191'b0, (isSmall ? doneSmall : doneBig)}, 192'd1);
        checkOutput({tag, "_held_result"}, isSmall ? {184'b0, resultSmall} : resultBig, expVal);
      end
    end else begin
      @(negedge clk);
      checkOutput({tag, "_done_one_cycle"}, {191'b0, (isSmall ? doneSmall : doneBig)}, 192'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    startBig = 1'b0; aBig = '0; bBig = '0;
    startSmall = 1'b0; aSmall = '0; bSmall = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_done_big", {191'b0, doneBig}, 192'd0);
      checkOutput("idle_result_big", resultBig, 192'd0);
      checkOutput("idle_done_small", {191'b0, doneSmall}, 192'd0);
      checkOutput("idle_result_small", {184'b0, resultSmall}, 192'd0);
    end

    // R mod M times 5 gives back 5
    applyStimulus(1'b0, 192'h000000000000000000000000000000010000000000000001, 192'd5,
                  192'd5, 1, "identity");
    @(negedge clk);
    startBig = 1'b0;
    // R^2 mod M times 3 converts 3 into Montgomery form
    applyStimulus(1'b0, 192'h000000000000000100000000000000020000000000000001, 192'd3,
                  192'h000000000000000000000000000000030000000000000003, 0, "convert");

    applyStimulus(1'b1, 192'h01, 192'h01, 192'hE1, 0, "small_rinv");
    applyStimulus(1'b1, 192'hEE, 192'h11, 192'hEE, 0, "small_max");
    applyStimulus(1'b1, 192'h00, 192'h55, 192'h00, 0, "small_zero");

    applyStimulus(1'b1, 192'h01, 192'h01, 192'hE1, 1, "b2b_op1");
    @(negedge clk);
    startSmall = 1'b0;
    applyStimulus(1'b1, 192'h11, 192'h22, 192'h22, 2, "b2b_op2");

    // abandon an operation mid-CALC; no expectation is queued for it
    @(negedge clk);
    aSmall = 8'hEE; bSmall = 8'h11; startSmall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    startSmall = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_done_small", {191'b0, doneSmall}, 192'd0);
    checkOutput("async_reset_result_small", {184'b0, resultSmall}, 192'd0);
    checkOutput("async_reset_result_big", resultBig, 192'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 192'hEE, 192'h11, 192'hEE, 0, "post_reset");

    repeat (5) @(negedge clk);
    checkOutput("big_scoreboard_drained", 192'(expBig.size()), 192'd0);
    checkOutput("small_scoreboard_drained", 192'(expSmall.size()), 192'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
